// File: rtl/yarvi_wb_pkg.sv
// Shared constants for the write-back stage: datapath sizes, register index width
// and the CSR counter-half select encodings.
package yarvi_wb_pkg;

  localparam int YARVI_XLEN = 32;
  localparam int YARVI_NREG = 32;
  localparam int YARVI_CNTW = 64;
  localparam int RIDX_W     = 5;

  typedef enum logic [1:0] {
    CSR_CYCLE_LO   = 2'd0,
    CSR_CYCLE_HI   = 2'd1,
    CSR_INSTRET_LO = 2'd2,
    CSR_INSTRET_HI = 2'd3
  } csr_sel_e;

endpackage

// File: rtl/yarvi_regfile.sv
// Integer register file: one write port, two combinational read ports with
// write-first bypass; x0 has no storage and always reads as zero.
module yarvi_regfile
  import yarvi_wb_pkg::*;
#(
  parameter int XLEN = YARVI_XLEN,
  parameter int NREG = YARVI_NREG
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              i_we,
  input  logic [RIDX_W-1:0] i_waddr,
  input  logic [XLEN-1:0]   i_wdata,
  input  logic [RIDX_W-1:0] i_rs1_addr,
  input  logic [RIDX_W-1:0] i_rs2_addr,
  output logic [XLEN-1:0]   o_rs1_data,
  output logic [XLEN-1:0]   o_rs2_data
);

  logic [XLEN-1:0] r_rf [1:NREG-1];
  logic            w_commit;

  assign w_commit = i_we && (i_waddr != '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 1; i < NREG; i++) r_rf[i] <= '0;
    end else if (w_commit) begin
      r_rf[i_waddr] <= i_wdata;
    end
  end

  // Bypass uses the same commit condition, so a write to x0 never leaks out.
  function automatic logic [XLEN-1:0] read_port(input logic [RIDX_W-1:0] a);
    if (a == '0)                        return '0;
    else if (w_commit && i_waddr == a)  return i_wdata;
    else                                return r_rf[a];
  endfunction

  always_comb begin
    o_rs1_data = read_port(i_rs1_addr);
    o_rs2_data = read_port(i_rs2_addr);
  end

endmodule

// File: rtl/yarvi_wb.sv
// Write-back stage: commits ME results to the register file, keeps trace
// registers and the cycle/instret counters with their CSR half-word port.
module yarvi_wb
  import yarvi_wb_pkg::*;
#(
  parameter int XLEN = YARVI_XLEN,
  parameter int NREG = YARVI_NREG,
  parameter int CNTW = YARVI_CNTW
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              me_valid,
  input  logic [RIDX_W-1:0] me_wb_rd,
  input  logic [XLEN-1:0]   me_wb_val,
  input  logic              me_load_hit_store,
  input  logic [RIDX_W-1:0] rs1_addr,
  input  logic [RIDX_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic [1:0]        csr_sel,
  input  logic              csr_we,
  input  logic [XLEN-1:0]   csr_wdata,
  output logic [XLEN-1:0]   csr_rdata,
  output logic              wb_valid,
  output logic [RIDX_W-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_val
);

  logic [CNTW-1:0]   r_cycle;
  logic [CNTW-1:0]   r_instret;
  logic              r_wb_valid_p1;
  logic [RIDX_W-1:0] r_wb_rd_p1;
  logic [XLEN-1:0]   r_wb_val_p1;
  csr_sel_e          w_sel;
  logic              w_retire;

  assign w_sel    = csr_sel_e'(csr_sel);
  // A hazarded slot is replayed later, so it retires only on its clean pass.
  assign w_retire = me_valid && !me_load_hit_store;

  yarvi_regfile #(.XLEN(XLEN), .NREG(NREG)) u_regfile (
    .clock      (clock),
    .reset      (reset),
    .i_we       (me_valid),
    .i_waddr    (me_wb_rd),
    .i_wdata    (me_wb_val),
    .i_rs1_addr (rs1_addr),
    .i_rs2_addr (rs2_addr),
    .o_rs1_data (rs1_data),
    .o_rs2_data (rs2_data)
  );

  // ME -> WB boundary: trace copy of the result triple.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wb_valid_p1 <= 1'b0;
      r_wb_rd_p1    <= '0;
      r_wb_val_p1   <= '0;
    end else begin
      r_wb_valid_p1 <= me_valid;
      r_wb_rd_p1    <= me_wb_rd;
      r_wb_val_p1   <= me_wb_val;
    end
  end

  // A CSR write to either half freezes that counter for the cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cycle   <= '0;
      r_instret <= '0;
    end else begin
      if (csr_we && w_sel == CSR_CYCLE_LO)
        r_cycle[XLEN-1:0] <= csr_wdata;
      else if (csr_we && w_sel == CSR_CYCLE_HI)
        r_cycle[CNTW-1:XLEN] <= csr_wdata;
      else
        r_cycle <= r_cycle + CNTW'(1);

      if (csr_we && w_sel == CSR_INSTRET_LO)
        r_instret[XLEN-1:0] <= csr_wdata;
      else if (csr_we && w_sel == CSR_INSTRET_HI)
        r_instret[CNTW-1:XLEN] <= csr_wdata;
      else if (w_retire)
        r_instret <= r_instret + CNTW'(1);
    end
  end

  always_comb begin
    csr_rdata = '0;
    case (w_sel)
      CSR_CYCLE_LO:   csr_rdata = r_cycle[XLEN-1:0];
      CSR_CYCLE_HI:   csr_rdata = r_cycle[CNTW-1:XLEN];
      CSR_INSTRET_LO: csr_rdata = r_instret[XLEN-1:0];
      CSR_INSTRET_HI: csr_rdata = r_instret[CNTW-1:XLEN];
      default:        csr_rdata = '0;
    endcase
  end

  assign wb_valid = r_wb_valid_p1;
  assign wb_rd    = r_wb_rd_p1;
  assign wb_val   = r_wb_val_p1;

endmodule

// File: tb/tb_yarvi_wb.sv
// Directed bench for yarvi_wb: commit/bypass, x0, retire counting with hazards,
// CSR half writes with carry and wrap, and reset dropping an in-flight result.
module tb_yarvi_wb;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        me_valid = 1'b0;
  logic [4:0]  me_wb_rd = '0;
  logic [31:0] me_wb_val = '0;
  logic        me_load_hit_store = 1'b0;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [1:0]  csr_sel = '0;
  logic        csr_we = 1'b0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_val;

  int total = 0;
  int bad   = 0;

  yarvi_wb dut (
    .clock             (clock),
    .reset             (reset),
    .me_valid          (me_valid),
    .me_wb_rd          (me_wb_rd),
    .me_wb_val         (me_wb_val),
    .me_load_hit_store (me_load_hit_store),
    .rs1_addr          (rs1_addr),
    .rs2_addr          (rs2_addr),
    .rs1_data          (rs1_data),
    .rs2_data          (rs2_data),
    .csr_sel           (csr_sel),
    .csr_we            (csr_we),
    .csr_wdata         (csr_wdata),
    .csr_rdata         (csr_rdata),
    .wb_valid          (wb_valid),
    .wb_rd             (wb_rd),
    .wb_val            (wb_val)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic csr_read(input logic [1:0] sel, output logic [31:0] val);
    csr_sel = sel;
    #1;
    val = csr_rdata;
  endtask

  task automatic read_regs(input logic [4:0] a1, input logic [4:0] a2);
    rs1_addr = a1;
    rs2_addr = a2;
    #1;
  endtask

  logic [31:0] v;

  initial begin
    // Reset, then 10 idle cycles
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    csr_read(2'd0, v); check("cycle_after_reset", v, 0);
    repeat (10) step();
    csr_read(2'd0, v); check("cycle_lo_10", v, 10);
    csr_read(2'd1, v); check("cycle_hi_0", v, 0);
    csr_read(2'd2, v); check("instret_lo_0", v, 0);
    read_regs(5'd5, 5'd31);
    check("rs1_idle", rs1_data, 0);
    check("rs2_idle", rs2_data, 0);
    check("wb_valid_idle", wb_valid, 0);

    // Commit with same-cycle bypass on both ports
    me_valid = 1'b1; me_wb_rd = 5'd5; me_wb_val = 32'h1234;
    read_regs(5'd5, 5'd5);
    check("rs1_bypass", rs1_data, 32'h1234);
    check("rs2_bypass", rs2_data, 32'h1234);
    step();
    me_valid = 1'b0; me_wb_val = 32'h0;
    #1;
    check("rs1_from_rf", rs1_data, 32'h1234);
    check("wb_valid_1", wb_valid, 1);
    check("wb_rd_5", wb_rd, 5);
    check("wb_val_1234", wb_val, 32'h1234);

    // Write to x0 is discarded but still retires
    me_valid = 1'b1; me_wb_rd = 5'd0; me_wb_val = 32'hFFFF_FFFF;
    read_regs(5'd0, 5'd0);
    check("rs1_x0", rs1_data, 0);
    check("rs2_x0", rs2_data, 0);
    step();
    me_valid = 1'b0;
    read_regs(5'd0, 5'd5);
    check("rs1_x0_after", rs1_data, 0);
    check("rs2_r5_kept", rs2_data, 32'h1234);
    check("wb_rd_0", wb_rd, 0);
    csr_read(2'd2, v); check("instret_2", v, 2);

    // Three results, middle hazarded: commits all, counts two
    me_valid = 1'b1; me_wb_rd = 5'd6; me_wb_val = 32'h11;
    step();
    me_wb_rd = 5'd8; me_wb_val = 32'h55; me_load_hit_store = 1'b1;
    step();
    me_wb_rd = 5'd9; me_wb_val = 32'h99; me_load_hit_store = 1'b0;
    step();
    me_valid = 1'b0;
    csr_read(2'd2, v); check("instret_4", v, 4);
    read_regs(5'd8, 5'd9);
    check("rs1_r8_hazard_commit", rs1_data, 32'h55);
    check("rs2_r9", rs2_data, 32'h99);
    read_regs(5'd6, 5'd0);
    check("rs1_r6", rs1_data, 32'h11);

    // Cycle lo write: read-before-write, then carry into hi
    csr_read(2'd0, v); check("cycle_lo_15", v, 15);
    csr_we = 1'b1; csr_wdata = 32'hFFFF_FFFF;
    #1;
    check("csr_read_old_on_write", csr_rdata, 15);
    step();
    csr_we = 1'b0;
    csr_read(2'd0, v); check("cycle_lo_written", v, 32'hFFFF_FFFF);
    csr_read(2'd1, v); check("cycle_hi_before_carry", v, 0);
    step();
    csr_read(2'd0, v); check("cycle_lo_carry", v, 0);
    csr_read(2'd1, v); check("cycle_hi_carry", v, 1);

    // Instret lo write beats a same-cycle retire; cycle keeps counting
    csr_sel = 2'd2; csr_we = 1'b1; csr_wdata = 32'h100;
    me_valid = 1'b1; me_wb_rd = 5'd0;
    step();
    csr_we = 1'b0; me_valid = 1'b0;
    csr_read(2'd2, v); check("instret_lo_written", v, 32'h100);
    csr_read(2'd3, v); check("instret_hi_0", v, 0);
    csr_read(2'd0, v); check("cycle_lo_1", v, 1);
    csr_read(2'd1, v); check("cycle_hi_1", v, 1);

    // Instret hi write freezes lo as well
    csr_sel = 2'd3; csr_we = 1'b1; csr_wdata = 32'h7;
    me_valid = 1'b1;
    step();
    csr_we = 1'b0; me_valid = 1'b0;
    csr_read(2'd3, v); check("instret_hi_written", v, 7);
    csr_read(2'd2, v); check("instret_lo_frozen", v, 32'h100);

    // Cycle wraps from all-ones to zero
    csr_sel = 2'd0; csr_we = 1'b1; csr_wdata = 32'hFFFF_FFFE;
    step();
    csr_sel = 2'd1; csr_wdata = 32'hFFFF_FFFF;
    step();
    csr_we = 1'b0;
    csr_read(2'd0, v); check("cycle_lo_frozen_by_hi_write", v, 32'hFFFF_FFFE);
    csr_read(2'd1, v); check("cycle_hi_all_ones", v, 32'hFFFF_FFFF);
    step();
    csr_read(2'd0, v); check("cycle_lo_all_ones", v, 32'hFFFF_FFFF);
    step();
    csr_read(2'd0, v); check("cycle_lo_wrap", v, 0);
    csr_read(2'd1, v); check("cycle_hi_wrap", v, 0);

    // Reset drops an in-flight result and clears state
    me_valid = 1'b1; me_wb_rd = 5'd7; me_wb_val = 32'hAA;
    step();
    me_valid = 1'b0;
    read_regs(5'd7, 5'd5);
    check("rs1_r7_aa", rs1_data, 32'hAA);
    reset = 1'b1;
    me_valid = 1'b1; me_wb_rd = 5'd7; me_wb_val = 32'hBB;
    step();
    reset = 1'b0; me_valid = 1'b0;
    read_regs(5'd7, 5'd5);
    check("rs1_r7_reset", rs1_data, 0);
    check("rs2_r5_reset", rs2_data, 0);
    csr_read(2'd0, v); check("cycle_reset", v, 0);
    csr_read(2'd3, v); check("instret_hi_reset", v, 0);
    csr_read(2'd2, v); check("instret_lo_reset", v, 0);
    check("wb_valid_reset", wb_valid, 0);
    check("wb_rd_reset", wb_rd, 0);
    check("wb_val_reset", wb_val, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/yarvi_wb.md
Name: yarvi_wb

Overview:
Write-back stage directly downstream of the memory/load-store unit. It consumes the ME result triple (valid, rd, value) and commits it to the integer register file. It serves two combinational register read ports to the decode/execute stages, with same-cycle write bypass. It also owns the 64-bit cycle and instret counters and their CSR read/write port.

Parameters:
XLEN, 32, datapath width in bits.
NREG, 32, number of architectural integer registers; x0 is hardwired to 0.
CNTW, 64, width of the cycle and instret counters.

Ports:
clock  in  1  system clock; all state updates on posedge.
reset  in  1  synchronous, active-high reset.
me_valid  in  1  ME result valid this cycle (retires one instruction).
me_wb_rd  in  5  destination register; 0 means no write.
me_wb_val  in  XLEN  value to write (load data or bypassed ALU result).
me_load_hit_store  in  1  ME hazard flag; when high, the upstream stage is stalled.
rs1_addr  in  5  read port 1 address.
rs2_addr  in  5  read port 2 address.
rs1_data  out  XLEN  read port 1 data, combinational.
rs2_data  out  XLEN  read port 2 data, combinational.
csr_sel  in  2  0=cycle lo, 1=cycle hi, 2=instret lo, 3=instret hi.
csr_we  in  1  write the selected 32-bit counter half.
csr_wdata  in  XLEN  CSR write data.
csr_rdata  out  XLEN  selected counter half, combinational; shows the pre-edge value.
wb_valid  out  1  registered copy of me_valid (trace/retire strobe).
wb_rd  out  5  registered copy of me_wb_rd.
wb_val  out  XLEN  registered copy of me_wb_val.

Behaviour:
- Commit rule: at posedge, if me_valid && me_wb_rd != 0 && !reset, then rf[me_wb_rd] <= me_wb_val.
- me_load_hit_store does not block commit; it only affects retire counting (see below).
- Read ports:
  - rsN_data = 0 if rsN_addr == 0.
  - Else me_wb_val if me_valid && me_wb_rd == rsN_addr (write-first bypass).
  - Else rf[rsN_addr].
  - The bypass applies independently per port; both ports may hit the same write.
- Trace regs: wb_valid/wb_rd/wb_val <= me_valid/me_wb_rd/me_wb_val every cycle, giving 1-cycle latency.
- cycle counter:
  - Increments by 1 every cycle not in reset.
  - Wraps at 2^64-1 -> 0.
  - Lower-half overflow carries into the upper half in the same cycle.
- instret counter:
  - Increments by 1 when me_valid && !me_load_hit_store.
  - A hazarded ME slot is replayed and re-presented later, so it is never counted twice.
- CSR write:
  - When csr_we, the selected 32-bit half <= csr_wdata at posedge.
  - The write takes priority over that counter's increment in the same cycle.
  - The other half of the same counter is left unchanged (no carry from the written half).
  - The other counter still increments normally.
- CSR read: csr_rdata reflects counter state before the current edge, so a read in the same cycle as a write returns the old value.
- Reset (synchronous, checked at posedge, overrides everything):
  - rf[1..31] <= 0.
  - cycle <= 0, instret <= 0.
  - wb_valid <= 0, wb_rd <= 0, wb_val <= 0.
  - A me_valid arriving in the reset cycle is dropped: no commit, no count.
- rsN_data and csr_rdata have no reset value of their own; they derive from state, so they are 0 after reset.
- x0: never written. No storage is required for entry 0.

Decomposition:
- Shared package/header (yarvi.h): CSR select encodings (CSR_CYCLE_LO/HI, CSR_INSTRET_LO/HI), the XLEN and NREG constants, and the register-index width.
- One natural sub-module, yarvi_regfile: 31x32 flop array, one write port, two combinational read ports with write-first bypass and x0 = 0.
- Counters and trace registers remain in yarvi_wb.

Test Plan:
- Reset then idle 10 cycles -> csr_sel=0 reads 10; instret reads 0; all rs reads 0.
- me_valid, rd=5, val=0x1234, rs1_addr=5 in the same cycle -> rs1_data=0x1234 that cycle; next cycle rs1_data=0x1234 from the rf; wb_valid=1, wb_rd=5.
- me_valid, rd=0, val=0xFFFFFFFF, rs1=rs2=0 -> rs1_data=rs2_data=0; rf unchanged; instret still +1.
- Three me_valid cycles, the middle one with me_load_hit_store=1 -> instret advances by 2.
- csr_we sel=0 wdata=0xFFFFFFFF, then 1 cycle idle -> cycle lo=0, hi=1. Separately: csr_we sel=2 with me_valid in the same cycle -> instret lo = wdata, no increment.
- Write rd=7=0xAA, then assert reset for one cycle with me_valid rd=7 val=0xBB -> rs1(7)=0; cycle=0; instret=0; wb_valid=0.
